// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide sequencer.
// Holds the op encodings, the FSM state enumeration, the iteration count,
// the divide-by-zero constants and small sign helpers.
package hilo_pkg;

    localparam int HILO_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Divide-by-zero: quotient forced to all ones, flag bit position in zon.
    localparam logic [31:0] DIVZ_LO  = 32'hFFFF_FFFF;
    localparam int          ZON_DZ   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Magnitude of x when it is a signed negative operand.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
        logic [31:0] r;
        r = (is_signed && x[31]) ? (32'd0 - x) : x;
        return r;
    endfunction

    // Conditional two's-complement negation of a 64-bit value.
    function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
        logic [63:0] r;
        r = en ? (64'd0 - x) : x;
        return r;
    endfunction

    // Conditional two's-complement negation of a 32-bit value.
    function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
        logic [31:0] r;
        r = en ? (32'd0 - x) : x;
        return r;
    endfunction

endpackage

// File: rtl/hilo_addsub.sv
// hilo_addsub: 33-bit adder/subtractor shared by the multiply shift-add
// step and the divide restoring shift-subtract step.
// Ports: x, y (33-bit operands), sub (1 = x - y, 0 = x + y), s (33-bit result).
module hilo_addsub (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] s
);
    assign s = sub ? (x - y) : (x + y);
endmodule

// File: rtl/hilo_seq.sv
// hilo_seq: iterative MIPS-style HI/LO unit for mult/multu/div/divu.
// A launched operation runs ITER shift-add / shift-subtract cycles, one
// sign-fix cycle and one done cycle; HI/LO and the flags are written when
// entering DONE.
// Ports: clk, rst (async, active-high), start/op/a/b launch an operation,
// mthi/mtlo/wdata write HI/LO directly while idle, busy/done status,
// hi/lo registers, zon = {zero, divide-by-zero, negative} flags.
module hilo_seq
    import hilo_pkg::*;
#(
    parameter int ITER = HILO_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [2:0]  zon
);

    state_t       state_r, state_next;
    logic [1:0]   op_r;
    logic [31:0]  ma_r, mb_r;      // operand magnitudes
    logic [31:0]  sh_r;            // multiplier (shifts right) / dividend (shifts left)
    logic         sa_r, sb_r;      // operand signs (only set for signed ops)
    logic         dz_r;            // divide by zero detected at launch
    logic [63:0]  acc_r;
    logic [4:0]   cnt_r;
    logic [31:0]  hi_r, lo_r;
    logic [2:0]   zon_r;
    logic         busy_r, done_r;

    logic         is_div_s, is_signed_s;
    logic [32:0]  as_x_s, as_y_s, as_s_s;
    logic         as_sub_s;
    logic [31:0]  rem_s;
    logic [63:0]  prod_s;
    logic [31:0]  res_hi_s, res_lo_s;
    logic [2:0]   res_zon_s;

    assign is_div_s    = op_r[1];
    assign is_signed_s = ~op_r[0];

    hilo_addsub u_addsub (
        .x   (as_x_s),
        .y   (as_y_s),
        .sub (as_sub_s),
        .s   (as_s_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next = ST_CALC;
                else       state_next = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == 5'(ITER - 1)) state_next = ST_FIX;
                else                       state_next = ST_CALC;
            end
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Adder operand selection: multiply adds the multiplicand when the
    // current multiplier bit is set; divide subtracts the divisor from the
    // partial remainder shifted left with the next dividend bit (33 bits,
    // since the shifted remainder can reach twice the divisor).
    always_comb begin
        as_x_s   = {1'b0, acc_r[63:32]};
        as_y_s   = {1'b0, (sh_r[0] ? ma_r : 32'd0)};
        as_sub_s = 1'b0;
        if (is_div_s) begin
            as_x_s   = {acc_r[63:32], sh_r[31]};
            as_y_s   = {1'b0, mb_r};
            as_sub_s = 1'b1;
        end else begin
            as_x_s   = {1'b0, acc_r[63:32]};
            as_y_s   = {1'b0, (sh_r[0] ? ma_r : 32'd0)};
            as_sub_s = 1'b0;
        end
    end

    // Restore step: a borrow (bit 32) means the divisor did not fit.
    assign rem_s = as_s_s[32] ? as_x_s[31:0] : as_s_s[31:0];

    // Sign correction and flag computation for the FIX cycle.
    always_comb begin
        prod_s    = neg64(acc_r, sa_r ^ sb_r);
        res_hi_s  = prod_s[63:32];
        res_lo_s  = prod_s[31:0];
        res_zon_s = 3'b000;
        if (is_div_s) begin
            if (dz_r) begin
                res_lo_s = DIVZ_LO;
                res_hi_s = neg32(ma_r, sa_r);
            end else begin
                res_lo_s = neg32(acc_r[31:0], sa_r ^ sb_r);
                res_hi_s = neg32(acc_r[63:32], sa_r);
            end
        end else begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
        res_zon_s[2]      = ({res_hi_s, res_lo_s} == 64'd0);
        res_zon_s[ZON_DZ] = dz_r;
        if (is_signed_s) res_zon_s[0] = is_div_s ? res_lo_s[31] : res_hi_s[31];
        else             res_zon_s[0] = 1'b0;
    end

    // Datapath: operand latch, iteration steps, HI/LO and flag writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= 2'b00;
            ma_r  <= 32'd0;
            mb_r  <= 32'd0;
            sh_r  <= 32'd0;
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
            dz_r  <= 1'b0;
            acc_r <= 64'd0;
            cnt_r <= 5'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
            zon_r <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        ma_r  <= abs32(a, ~op[0]);
                        mb_r  <= abs32(b, ~op[0]);
                        sa_r  <= ~op[0] & a[31];
                        sb_r  <= ~op[0] & b[31];
                        dz_r  <= op[1] & (b == 32'd0);
                        // Multiply consumes |b| from the LSB, divide consumes |a| from the MSB.
                        sh_r  <= op[1] ? abs32(a, ~op[0]) : abs32(b, ~op[0]);
                        acc_r <= 64'd0;
                        cnt_r <= 5'd0;
                    end else begin
                        if (mthi) hi_r <= wdata;
                        if (mtlo) lo_r <= wdata;
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (is_div_s) begin
                        acc_r <= {rem_s, acc_r[30:0], ~as_s_s[32]};
                        sh_r  <= {sh_r[30:0], 1'b0};
                    end else begin
                        acc_r <= {as_s_s, acc_r[31:1]};
                        sh_r  <= {1'b0, sh_r[31:1]};
                    end
                end
                ST_FIX: begin
                    hi_r  <= res_hi_s;
                    lo_r  <= res_lo_s;
                    zon_r <= res_zon_s;
                end
                ST_DONE: begin
                    cnt_r <= 5'd0;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Registered status outputs, derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next != ST_IDLE);
            done_r <= (state_next == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign zon  = zon_r;

endmodule
